// File: rtl/breath_sched_if.sv
// Bundles the breath scheduler control, LUT and PWM signals.
// master = controlling/LUT side, slave = scheduler side.
interface breath_sched_if #(
  parameter int CHANNELS = 4
);
  logic                start;
  logic                stop;
  logic                loop;
  logic [CHANNELS-1:0] enable_sw;
  logic [5:0]          lut_addr;
  logic [5:0]          lut_data;
  logic [CHANNELS-1:0] pwm;
  logic                busy;
  logic                done;

  modport master (
    output start, stop, loop, enable_sw, lut_data,
    input  lut_addr, pwm, busy, done
  );

  modport slave (
    input  start, stop, loop, enable_sw, lut_data,
    output lut_addr, pwm, busy, done
  );
endinterface

// File: rtl/breath_sched.sv
// Multi-channel "breathing" PWM scheduler: per step it fetches one duty per
// channel from a shared 64-entry LUT, then runs one 64-tick PWM period.
module breath_sched #(
  parameter int CHANNELS = 4,
  parameter int PRESCALE = 2
) (
  input  logic          sysclk,
  input  logic          rst_n,
  breath_sched_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    RUN   = 2'd2
  } state_t;

  localparam int         STRIDE    = 64 / CHANNELS;
  localparam logic [7:0] PRESC_MAX = 8'(PRESCALE - 1);
  localparam logic [2:0] PTR_LAST  = 3'(CHANNELS - 1);

  state_t              state_reg;
  state_t              state_next;
  logic [5:0]          index_reg;
  logic [5:0]          count_reg;
  logic [7:0]          presc_reg;
  logic [2:0]          ptr_reg;
  logic                done_reg;
  logic                tick;
  logic                period_end;
  logic                fetch_last;
  logic                last_breath;
  logic [5:0]          fetch_offset;
  logic [CHANNELS-1:0] pwm_raw;

  assign tick         = (state_reg == RUN) && (presc_reg == PRESC_MAX);
  assign period_end   = tick && (count_reg == 6'd63);
  assign fetch_last   = (state_reg == FETCH) && (ptr_reg == PTR_LAST);
  assign last_breath  = period_end && (index_reg == 6'd63) && !bus.loop;
  // Channels are spread evenly around the LUT; 6-bit truncation gives the mod-64 wrap.
  assign fetch_offset = 6'(int'(ptr_reg) * STRIDE);

  // State register
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; stop overrides everything, including a same-cycle start
  always_comb begin
    state_next = state_reg;
    if (bus.stop) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE:    if (bus.start) state_next = FETCH;
        FETCH:   if (fetch_last) state_next = RUN;
        RUN:     if (period_end) state_next = last_breath ? IDLE : FETCH;
        default: state_next = IDLE;
      endcase
    end
  end

  // Output logic
  always_comb begin
    bus.busy     = (state_reg != IDLE);
    bus.lut_addr = 6'd0;
    if (state_reg == FETCH) begin
      bus.lut_addr = index_reg + fetch_offset;
    end
    bus.pwm  = (state_reg == RUN) ? (pwm_raw & bus.enable_sw) : '0;
    bus.done = done_reg;
  end

  // Step index, PWM count, prescaler and fetch pointer
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      index_reg <= 6'd0;
      count_reg <= 6'd0;
      presc_reg <= 8'd0;
      ptr_reg   <= 3'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.start && !bus.stop) begin
            index_reg <= 6'd0;
            count_reg <= 6'd0;
            presc_reg <= 8'd0;
            ptr_reg   <= 3'd0;
          end
        end
        FETCH: begin
          if (fetch_last) begin
            ptr_reg   <= 3'd0;
            count_reg <= 6'd0;
            presc_reg <= 8'd0;
          end else begin
            ptr_reg <= ptr_reg + 3'd1;
          end
        end
        RUN: begin
          if (tick) begin
            presc_reg <= 8'd0;
            count_reg <= count_reg + 6'd1;
            if (count_reg == 6'd63) begin
              index_reg <= index_reg + 6'd1;
            end
          end else begin
            presc_reg <= presc_reg + 8'd1;
          end
        end
        default: begin
          ptr_reg <= 3'd0;
        end
      endcase
    end
  end

  // Completion pulse lands in the first IDLE cycle, together with busy falling
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      done_reg <= 1'b0;
    end else begin
      done_reg <= last_breath && !bus.stop;
    end
  end

  // Per-channel duty register and comparator
  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
      logic [5:0] duty_reg;

      always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
          duty_reg <= 6'd0;
        end else if ((state_reg == FETCH) && (ptr_reg == 3'(gi))) begin
          duty_reg <= bus.lut_data;
        end
      end

      assign pwm_raw[gi] = (count_reg < duty_reg);
    end
  endgenerate

endmodule

// File: tb/tb_breath_sched.sv
// Directed bench for breath_sched (4 channels, prescale 2) with an identity LUT.
// Table vectors cover start/fetch/early RUN; hand sequences cover long-run corners.
module tb_breath_sched;

  localparam int STEP_CYC = 132;
  localparam int DONE_T   = 64 * STEP_CYC;

  logic clk;
  logic rst_n;
  int   nvec;
  int   nbad;

  breath_sched_if #(.CHANNELS(4)) bus ();

  breath_sched #(
    .CHANNELS(4),
    .PRESCALE(2)
  ) dut (
    .sysclk(clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  assign bus.lut_data = bus.lut_addr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       start;
    logic       stop;
    logic       loop;
    logic [3:0] en;
    logic       exp_busy;
    logic       exp_done;
    logic [5:0] exp_addr;
    logic [3:0] exp_pwm;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.stop      = 1'b0;
    bus.loop      = 1'b0;
    bus.enable_sw = 4'hF;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t;
    int h0, h1, h2, h3, h3s15, ndone, done_t;

    nvec = 0;
    nbad = 0;
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.stop      = 1'b0;
    bus.loop      = 1'b0;
    bus.enable_sw = 4'hF;

    //            start stop loop en     busy done addr   pwm
    tbl[0] = '{1'b1, 1'b0, 1'b0, 4'hF, 1'b0, 1'b0, 6'd0,  4'b0000};
    tbl[1] = '{1'b0, 1'b0, 1'b0, 4'hF, 1'b1, 1'b0, 6'd0,  4'b0000};
    tbl[2] = '{1'b0, 1'b0, 1'b0, 4'hF, 1'b1, 1'b0, 6'd16, 4'b0000};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 4'hF, 1'b1, 1'b0, 6'd32, 4'b0000};
    tbl[4] = '{1'b0, 1'b0, 1'b0, 4'hF, 1'b1, 1'b0, 6'd48, 4'b0000};
    tbl[5] = '{1'b0, 1'b0, 1'b0, 4'hF, 1'b1, 1'b0, 6'd0,  4'b1110};
    tbl[6] = '{1'b1, 1'b0, 1'b0, 4'hF, 1'b1, 1'b0, 6'd0,  4'b1110};
    tbl[7] = '{1'b0, 1'b0, 1'b0, 4'h5, 1'b1, 1'b0, 6'd0,  4'b0100};
    tbl[8] = '{1'b0, 1'b0, 1'b0, 4'hA, 1'b1, 1'b0, 6'd0,  4'b1010};
    tbl[9] = '{1'b0, 1'b0, 1'b0, 4'hF, 1'b1, 1'b0, 6'd0,  4'b1110};

    // Outputs while reset is held
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_addr", bus.lut_addr, 0);
    chk("rst_pwm", bus.pwm, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("post_rst_idle", bus.busy, 0);

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.start     = tbl[i].start;
      bus.stop      = tbl[i].stop;
      bus.loop      = tbl[i].loop;
      bus.enable_sw = tbl[i].en;
      #1;
      $display("vec %0d: busy=%0d done=%0d addr=%0d pwm=%b", i, bus.busy, bus.done,
               bus.lut_addr, bus.pwm);
      chk($sformatf("v%0d_busy", i), bus.busy, tbl[i].exp_busy);
      chk($sformatf("v%0d_done", i), bus.done, tbl[i].exp_done);
      chk($sformatf("v%0d_addr", i), bus.lut_addr, tbl[i].exp_addr);
      chk($sformatf("v%0d_pwm", i), bus.pwm, tbl[i].exp_pwm);
    end

    // Sequence A: single breath to completion
    do_reset();
    @(negedge clk);
    bus.start = 1'b1;
    #1;
    @(negedge clk);
    bus.start = 1'b0;
    h0 = 0; h1 = 0; h2 = 0; h3 = 0; h3s15 = 0; done_t = -1;
    for (t = 0; t < DONE_T + 100; t++) begin
      if (t > 0) @(negedge clk);
      #1;
      if (t < 4) chk("A_fetch_addr", bus.lut_addr, t * 16);
      if (t >= 4 && t < STEP_CYC) begin
        h0 += int'(bus.pwm[0]);
        h1 += int'(bus.pwm[1]);
        h2 += int'(bus.pwm[2]);
        h3 += int'(bus.pwm[3]);
      end
      if (t >= STEP_CYC && t < STEP_CYC + 4) begin
        chk("A_step1_addr", bus.lut_addr, 1 + 16 * (t - STEP_CYC));
        chk("A_gap_pwm", bus.pwm, 0);
      end
      if (t >= 15 * STEP_CYC + 4 && t < 16 * STEP_CYC) h3s15 += int'(bus.pwm[3]);
      if (bus.done) begin
        done_t = t;
        chk("A_busy_at_done", bus.busy, 0);
        break;
      end
    end
    chk("A_done_time", done_t, DONE_T);
    @(negedge clk);
    #1;
    chk("A_done_width", bus.done, 0);
    chk("A_idle_after", bus.busy, 0);
    chk("A_pwm0_highs", h0, 0);
    chk("A_pwm1_highs", h1, 32);
    chk("A_pwm2_highs", h2, 64);
    chk("A_pwm3_highs", h3, 96);
    chk("A_duty63_highs", h3s15, 126);
    $display("seqA: done at t=%0d highs=%0d/%0d/%0d/%0d duty63=%0d", done_t, h0, h1, h2, h3, h3s15);

    // Sequence B: looping wraps the index with no done pulse
    do_reset();
    @(negedge clk);
    bus.start = 1'b1;
    bus.loop  = 1'b1;
    #1;
    @(negedge clk);
    bus.start = 1'b0;
    ndone = 0;
    for (t = 0; t <= DONE_T + 4; t++) begin
      if (t > 0) @(negedge clk);
      #1;
      ndone += int'(bus.done);
      if (t >= DONE_T && t < DONE_T + 4) begin
        chk("B_wrap_addr", bus.lut_addr, 16 * (t - DONE_T));
        chk("B_wrap_busy", bus.busy, 1);
      end
    end
    chk("B_run_pwm", bus.pwm, 4'b1110);
    chk("B_no_done", ndone, 0);
    $display("seqB: done pulses=%0d", ndone);

    // Sequence C: stop mid-RUN, then start+stop together in IDLE
    @(negedge clk);
    bus.stop = 1'b1;
    #1;
    chk("C_pwm_before_stop", bus.pwm, 4'b1110);
    @(negedge clk);
    bus.stop = 1'b0;
    #1;
    chk("C_stop_busy", bus.busy, 0);
    chk("C_stop_pwm", bus.pwm, 0);
    chk("C_stop_done", bus.done, 0);
    @(negedge clk);
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    #1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    #1;
    chk("C_startstop_busy", bus.busy, 0);
    chk("C_startstop_addr", bus.lut_addr, 0);
    chk("C_startstop_done", bus.done, 0);
    $display("seqC: busy=%0d pwm=%b after stop", bus.busy, bus.pwm);

    // Sequence D: asynchronous reset mid-FETCH of step 1, then restart
    do_reset();
    bus.loop = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
    #1;
    @(negedge clk);
    bus.start = 1'b0;
    for (t = 0; t <= STEP_CYC + 1; t++) begin
      if (t > 0) @(negedge clk);
      #1;
    end
    chk("D_pre_addr", bus.lut_addr, 17);
    #1;
    rst_n = 1'b0;
    #1;
    chk("D_rst_busy", bus.busy, 0);
    chk("D_rst_addr", bus.lut_addr, 0);
    chk("D_rst_pwm", bus.pwm, 0);
    chk("D_rst_done", bus.done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("D_idle_after_rst", bus.busy, 0);
    @(negedge clk);
    bus.start = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      #1;
      chk("D_restart_addr", bus.lut_addr, 16 * k);
    end
    $display("seqD: restart addresses checked");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
